chimp_game_core: RTL and testbench

- Parametrised successor to the fixed 3x3 game core: an ROWS x COLS number grid with self-placed numbers, a reveal timer, level progression and scoring.
- Sits between the player cursor block and the per-cell display_number renderers.
- Supplies a read port so the renderer can fetch any cell's number and hidden flag.

---
 rtl/chimp_game_core.sv | 180 ++++++++++++++++++
 tb/tb_chimp_game_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chimp_game_core.sv
// Chimp memory-game core: ROWS x COLS number grid, self-placed numbers, reveal timer, levels, score.
// Define CHIMP_FIXED_LAYOUT_EN for deterministic row-major placement instead of LFSR placement.
module chimp_game_core #(
    parameter int unsigned ROWS          = 3,
    parameter int unsigned COLS          = 3,
    parameter int unsigned MIN_NUMS      = 4,
    parameter int unsigned REVEAL_CYCLES = 50_000_000,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int unsigned CELLS = ROWS * COLS,
    localparam int unsigned NUM_W = $clog2(CELLS + 1),
    localparam int unsigned RW    = $clog2(ROWS),
    localparam int unsigned CW    = $clog2(COLS),
    localparam int unsigned IDX_W = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [RW-1:0]    cur_row,
    input  logic [CW-1:0]    cur_col,
    input  logic [RW-1:0]    rd_row,
    input  logic [CW-1:0]    rd_col,
    output logic [NUM_W-1:0] rd_num,
    output logic             rd_hidden,
    output logic [2:0]       state,
    output logic [NUM_W-1:0] num_count,
    output logic [NUM_W-1:0] target,
    output logic [15:0]      score
);

    localparam int unsigned TMR_W   = (REVEAL_CYCLES > 0) ? $clog2(REVEAL_CYCLES + 1) : 1;
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_VISIBLE = 3'd2,
        S_HIDDEN  = 3'd3,
        S_WON     = 3'd4,
        S_LOST    = 3'd5
    } state_t;

    state_t             state_q, state_n;
    logic [NUM_W-1:0]   grid_q [CELLS];
    logic [NUM_W-1:0]   grid_n [CELLS];
    logic [NUM_W-1:0]   k_q, k_n;
    logic [NUM_W-1:0]   target_q, target_n;
    logic [NUM_W-1:0]   num_count_q, num_count_n;
    logic [15:0]        score_q, score_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic [15:0]        lfsr_q, lfsr_n;
    logic               sel_d_q;

    logic               sel_rise, cur_ok, sel_valid, rd_ok, place_ok;
    logic [IDX_W-1:0]   cur_idx, rd_idx, place_idx;
    logic [NUM_W-1:0]   sel_val;
    logic [16:0]        score_sum;

    // Cursor / read addressing; out-of-grid coordinates never alias a real cell
    assign sel_rise  = sel & ~sel_d_q;
    assign cur_ok    = ({1'b0, cur_row} < (RW+1)'(ROWS)) && ({1'b0, cur_col} < (CW+1)'(COLS));
    assign cur_idx   = IDX_W'(32'(cur_row) * COLS + 32'(cur_col));
    assign sel_valid = sel_rise & cur_ok;
    assign sel_val   = cur_ok ? grid_q[cur_idx] : '0;

    assign rd_ok     = ({1'b0, rd_row} < (RW+1)'(ROWS)) && ({1'b0, rd_col} < (CW+1)'(COLS));
    assign rd_idx    = IDX_W'(32'(rd_row) * COLS + 32'(rd_col));
    assign rd_num    = rd_ok ? grid_q[rd_idx] : '0;
    assign rd_hidden = (state_q == S_HIDDEN) && (rd_num != '0);

    assign lfsr_n    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign score_sum = {1'b0, score_q} + 17'(num_count_q);

`ifdef CHIMP_FIXED_LAYOUT_EN
    assign place_idx = IDX_W'(k_q - NUM_W'(1));
    assign place_ok  = 1'b1;
`else
    assign place_idx = lfsr_q[IDX_W-1:0];
    assign place_ok  = ({1'b0, place_idx} < (IDX_W+1)'(CELLS)) && (grid_q[place_idx] == '0);
`endif

    // Next-state and datapath updates; k==0 in LOAD marks the grid-clear cycle
    always_comb begin
        state_n     = state_q;
        grid_n      = grid_q;
        k_n         = k_q;
        target_n    = target_q;
        num_count_n = num_count_q;
        score_n     = score_q;
        timer_n     = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    k_n     = '0;
                end
            end
            S_LOAD: begin
                if (k_q == '0) begin
                    for (int i = 0; i < int'(CELLS); i++) grid_n[i] = '0;
                    k_n      = NUM_W'(1);
                    target_n = NUM_W'(1);
                end else if (place_ok) begin
                    grid_n[place_idx] = k_q;
                    k_n               = k_q + NUM_W'(1);
                    if (k_q == num_count_q) begin
                        state_n = S_VISIBLE;
                        timer_n = TMR_W'(REVEAL_CYCLES);
                    end
                end
            end
            S_VISIBLE, S_HIDDEN: begin
                if (state_q == S_VISIBLE && timer_q != '0) timer_n = timer_q - TMR_W'(1);
                if (sel_valid) begin
                    if (sel_val == target_q) begin
                        grid_n[cur_idx] = '0;
                        target_n        = target_q + NUM_W'(1);
                        if (target_q == num_count_q) begin
                            state_n = S_WON;
                            score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        end else begin
                            state_n = S_HIDDEN;
                        end
                    end else if (sel_val != '0) begin
                        state_n = S_LOST;
                    end
                end else if (state_q == S_VISIBLE && timer_q == TMR_W'(1)) begin
                    state_n = S_HIDDEN;
                end
            end
            S_WON: begin
                if (start) begin
                    state_n = S_LOAD;
                    k_n     = '0;
                    if (num_count_q != NUM_W'(CELLS)) num_count_n = num_count_q + NUM_W'(1);
                end
            end
            S_LOST: begin
                if (start) begin
                    state_n     = S_LOAD;
                    k_n         = '0;
                    num_count_n = NUM_W'(MIN_NUMS);
                    score_n     = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; LFSR free-runs to collect player-timing entropy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < int'(CELLS); i++) grid_q[i] <= '0;
            k_q         <= '0;
            target_q    <= NUM_W'(1);
            num_count_q <= NUM_W'(MIN_NUMS);
            score_q     <= '0;
            timer_q     <= '0;
            lfsr_q      <= SEED_NZ;
            sel_d_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            for (int i = 0; i < int'(CELLS); i++) grid_q[i] <= grid_n[i];
            k_q         <= k_n;
            target_q    <= target_n;
            num_count_q <= num_count_n;
            score_q     <= score_n;
            timer_q     <= timer_n;
            lfsr_q      <= lfsr_n;
            sel_d_q     <= sel;
        end
    end

    assign state     = state_q;
    assign num_count = num_count_q;
    assign target    = target_q;
    assign score     = score_q;

endmodule

// File: tb/tb_chimp_game_core.sv
// Bench for chimp_game_core: directed game steps plus randomized play against a rule-level game model.
module tb_chimp_game_core;

    localparam int ROWS     = 3;
    localparam int COLS     = 3;
    localparam int CELLS    = 9;
    localparam int MIN_NUMS = 4;
    localparam int REVEAL   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, sel = 1'b0;
    logic [1:0] cur_row = '0, cur_col = '0, rd_row = '0, rd_col = '0;
    logic [3:0] rd_num, num_count, target;
    logic       rd_hidden;
    logic [2:0] state;
    logic [15:0] score;

    logic       b_start = 1'b0, b_sel = 1'b0;
    logic [1:0] b_cur_row = '0, b_cur_col = '0, b_rd_row = '0, b_rd_col = '0;
    logic [4:0] b_rd_num, b_num_count, b_target;
    logic       b_rd_hidden;
    logic [2:0] b_state;
    logic [15:0] b_score;

    chimp_game_core #(.ROWS(3), .COLS(3), .MIN_NUMS(4), .REVEAL_CYCLES(10), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
        .cur_row(cur_row), .cur_col(cur_col), .rd_row(rd_row), .rd_col(rd_col),
        .rd_num(rd_num), .rd_hidden(rd_hidden), .state(state),
        .num_count(num_count), .target(target), .score(score)
    );

    chimp_game_core #(.ROWS(4), .COLS(4), .MIN_NUMS(16), .REVEAL_CYCLES(0), .SEED(16'h1234)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .sel(b_sel),
        .cur_row(b_cur_row), .cur_col(b_cur_col), .rd_row(b_rd_row), .rd_col(b_rd_col),
        .rd_num(b_rd_num), .rd_hidden(b_rd_hidden), .state(b_state),
        .num_count(b_num_count), .target(b_target), .score(b_score)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_grid [CELLS];
    int lay [16];
    int pos [17];
    int m_state, m_target, m_n, m_score;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reads the whole grid; numbers 1..n must each appear exactly once, nothing else nonzero
    task automatic scan(input bit big, input int n, input string tag);
        int cnt [17];
        int bad, dim, v;
        bad = 0;
        dim = big ? 4 : 3;
        foreach (cnt[i]) cnt[i] = 0;
        for (int r = 0; r < dim; r++) begin
            for (int c = 0; c < dim; c++) begin
                if (big) begin
                    b_rd_row = 2'(r); b_rd_col = 2'(c); #1; v = int'(b_rd_num);
                end else begin
                    rd_row = 2'(r); rd_col = 2'(c); #1; v = int'(rd_num);
                end
                lay[r*dim+c] = v;
                if (v > n) bad++;
                else if (v != 0) cnt[v]++;
            end
        end
        for (int k = 1; k <= n; k++) if (cnt[k] != 1) bad++;
        chk({tag, "_layout"}, bad, 0);
`ifdef CHIMP_FIXED_LAYOUT_EN
        for (int k = 1; k <= n; k++) chk({tag, "_fixed"}, lay[k-1], k);
`endif
        if (!big) begin
            for (int i = 0; i < CELLS; i++) begin
                m_grid[i] = lay[i];
                if (lay[i] > 0 && lay[i] <= 16) pos[lay[i]] = i;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_state"}, int'(state), m_state);
        chk({tag, "_target"}, int'(target), m_target);
        chk({tag, "_score"}, int'(score), m_score);
        chk({tag, "_num_count"}, int'(num_count), m_n);
    endtask

    task automatic model_sel(input int r, input int c);
        int v;
        if ((m_state == 2 || m_state == 3) && r < ROWS && c < COLS) begin
            v = m_grid[r*COLS+c];
            if (v == m_target) begin
                m_grid[r*COLS+c] = 0;
                if (m_target == m_n) begin
                    m_state = 4;
                    m_score = (m_score + m_n > 65535) ? 65535 : m_score + m_n;
                end else begin
                    m_state = 3;
                end
                m_target++;
            end else if (v != 0) begin
                m_state = 5;
            end
        end
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 4 || m_state == 5) begin
            if (m_state == 4) m_n = (m_n + 1 > CELLS) ? CELLS : m_n + 1;
            else if (m_state == 5) begin m_n = MIN_NUMS; m_score = 0; end
            m_state = 1;
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic do_sel(input int r, input int c);
        @(negedge clk); cur_row = 2'(r); cur_col = 2'(c); sel = 1'b1;
        @(negedge clk); sel = 1'b0;
    endtask

    task automatic wait_load(output int n);
        n = 0;
        while (state == 3'd1 && n < 2000) begin @(negedge clk); n++; end
        chk("load_done_state", int'(state), 2);
        chk("load_done_target", int'(target), 1);
        m_state  = 2;
        m_target = 1;
    endtask

    task automatic wait_hide();
        int vis;
        vis = 0;
        while (state == 3'd2 && vis < 100) begin @(negedge clk); vis++; end
        chk("reveal_cycles", vis, REVEAL);
        chk("reveal_hidden_state", int'(state), 3);
        m_state = 3;
    endtask

    initial begin
        int n, empty_cell;
        #10 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        m_state = 0; m_n = MIN_NUMS; m_target = 1; m_score = 0;
        check_model("reset");
        scan(1'b0, 0, "reset_grid");
        @(negedge clk); rst_n = 1'b1;

        // First level: load, reveal, auto-hide
        do_start; model_start;
        check_model("start_idle");
        wait_load(n);
`ifdef CHIMP_FIXED_LAYOUT_EN
        chk("load_cycles", n, MIN_NUMS + 1);
`else
        chk("load_cycles_min", int'(n >= MIN_NUMS + 1), 1);
`endif
        scan(1'b0, MIN_NUMS, "lvl1");
        rd_row = 2'(pos[1] / COLS); rd_col = 2'(pos[1] % COLS); #1;
        chk("visible_not_hidden", int'(rd_hidden), 0);
        wait_hide;
        #1 chk("hidden_flag_num", int'(rd_hidden), 1);
        empty_cell = 0;
        for (int i = CELLS - 1; i >= 0; i--) if (m_grid[i] == 0) empty_cell = i;
        rd_row = 2'(empty_cell / COLS); rd_col = 2'(empty_cell % COLS); #1;
        chk("hidden_flag_empty", int'(rd_hidden), 0);

        do_start; model_start;
        check_model("start_ignored_hidden");

        // Held select acts once, even after the cursor moves onto the next target
        @(negedge clk); cur_row = 2'(pos[1] / COLS); cur_col = 2'(pos[1] % COLS); sel = 1'b1;
        @(negedge clk); cur_row = 2'(pos[2] / COLS); cur_col = 2'(pos[2] % COLS);
        repeat (99) @(negedge clk);
        sel = 1'b0;
        model_sel(pos[1] / COLS, pos[1] % COLS);
        check_model("sel_held");

        do_sel(empty_cell / COLS, empty_cell % COLS); model_sel(empty_cell / COLS, empty_cell % COLS);
        check_model("sel_empty");
        do_sel(3, pos[2] % COLS); model_sel(3, pos[2] % COLS);
        check_model("sel_row_oob");
        do_sel(pos[2] / COLS, 3); model_sel(pos[2] / COLS, 3);
        check_model("sel_col_oob");
        for (int v = 2; v <= MIN_NUMS; v++) begin
            do_sel(pos[v] / COLS, pos[v] % COLS); model_sel(pos[v] / COLS, pos[v] % COLS);
            check_model("sel_order");
        end

        // Level up, then lose with an out-of-order pick while numbers are visible
        do_start; model_start;
        check_model("start_won");
        wait_load(n);
        scan(1'b0, MIN_NUMS + 1, "lvl2");
        do_sel(pos[2] / COLS, pos[2] % COLS); model_sel(pos[2] / COLS, pos[2] % COLS);
        check_model("wrong_pick");
        rd_row = 2'(pos[2] / COLS); rd_col = 2'(pos[2] % COLS); #1;
        chk("lost_rd_num", int'(rd_num), 2);
        chk("lost_rd_hidden", int'(rd_hidden), 0);
        do_start; model_start;
        check_model("start_lost");
        wait_load(n);
        scan(1'b0, MIN_NUMS, "lvl3");

        // Valid select on the very cycle the timer expires
        repeat (REVEAL - 1) @(negedge clk);
        chk("pre_timeout_state", int'(state), 2);
        cur_row = 2'(pos[1] / COLS); cur_col = 2'(pos[1] % COLS); sel = 1'b1;
        @(negedge clk); sel = 1'b0;
        model_sel(pos[1] / COLS, pos[1] % COLS);
        check_model("sel_on_timeout");

        // Randomized play: mostly correct picks, some arbitrary (incl. off-grid) cursors
        for (int round = 0; round < 8; round++) begin
            int steps;
            steps = 0;
            while ((m_state == 2 || m_state == 3) && steps < 200) begin
                int r, c;
                if ($urandom_range(3) != 0) begin
                    r = pos[m_target] / COLS; c = pos[m_target] % COLS;
                end else begin
                    r = int'($urandom_range(3)); c = int'($urandom_range(3));
                end
                do_sel(r, c); model_sel(r, c);
                check_model("rnd");
                if (r < ROWS && c < COLS) begin
                    rd_row = 2'(r); rd_col = 2'(c); #1;
                    chk("rnd_rd_num", int'(rd_num), m_grid[r*COLS+c]);
                end
                steps++;
            end
            do_start; model_start;
            check_model("rnd_start");
            wait_load(n);
            scan(1'b0, m_n, "rnd_lvl");
            wait_hide;
        end

        // Asynchronous reset in the middle of a hidden round
        @(negedge clk); #7 rst_n = 1'b0; #1;
        m_state = 0; m_n = MIN_NUMS; m_target = 1; m_score = 0;
        check_model("reset_mid");
        scan(1'b0, 0, "reset_mid_grid");
        @(negedge clk); rst_n = 1'b1;

        // Full 4x4 grid, random placement, no reveal timeout
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        n = 0;
        while (b_state == 3'd1 && n < 5000) begin @(negedge clk); n++; end
        chk("big_load_done", int'(b_state), 2);
        chk("big_num_count", int'(b_num_count), 16);
        scan(1'b1, 16, "big");
        b_rd_row = 2'd3; b_rd_col = 2'd3; #1;
        chk("big_rd33_nonzero", int'(b_rd_num != 5'd0), 1);
        repeat (30) @(negedge clk);
        chk("big_no_timeout", int'(b_state), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
